probe_led_monitor: RTL and testbench

//   Parametrised LED status driver for the Processor top: generalises the fixed four led_prob_* outputs
//   and led_synth heartbeat into NUM_CH probe channels, each with a run-time selectable display mode.

---
 rtl/probe_led_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_probe_led_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/probe_led_monitor.sv
`default_nettype none
// ============================================================================
// Module   : probe_led_monitor
// Purpose  : LED status driver for the processor top. Drives NUM_CH probe
//            LEDs, each with a run-time selectable display mode, plus a
//            free-running heartbeat LED.
//            Modes: 0 DIRECT, 1 STICKY, 2 STRETCH, 3 BLINK.
// Ports    : clk_i        system clock, rising edge
//            reset_i      asynchronous active-high reset
//            probe_i      probe taps, synchronous to clk_i
//            clear_i      per-channel clear of the STICKY latch
//            cfg_we_i     mode write strobe
//            cfg_ch_i     channel index for the mode write
//            cfg_mode_i   mode value to write
//            led_prob_o   per-channel LED drive (bit i = channel i)
//            led_any_o    registered OR of led_prob_o
//            led_synth_o  heartbeat, period 2*HB_DIV cycles
// Revision : 1.0  initial release
// ============================================================================
module probe_led_monitor #(
  parameter int NUM_CH         = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int BLINK_DIV      = 8,
  parameter int HB_DIV         = 25000000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] probe_i,
  input  logic [NUM_CH-1:0] clear_i,
  input  logic              cfg_we_i,
  input  logic [4:0]        cfg_ch_i,
  input  logic [1:0]        cfg_mode_i,
  output logic [NUM_CH-1:0] led_prob_o,
  output logic              led_any_o,
  output logic              led_synth_o
);

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'd0,
    MODE_STICKY  = 2'd1,
    MODE_STRETCH = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  // Stretch counter must hold the value STRETCH_CYCLES itself.
  localparam int                   c_CNT_W        = $clog2(STRETCH_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]   c_STRETCH_LOAD = c_CNT_W'(STRETCH_CYCLES);
  localparam int                   c_PRE_W        = $clog2(BLINK_DIV);
  localparam logic [c_PRE_W-1:0]   c_PRE_LAST     = c_PRE_W'(BLINK_DIV - 1);
  localparam int                   c_HB_W         = $clog2(HB_DIV);
  localparam logic [c_HB_W-1:0]    c_HB_LAST      = c_HB_W'(HB_DIV - 1);

  // --------------------------------------------------------------------------
  // Shared blink prescaler: free-runs regardless of any channel's state, so
  // all blinking channels toggle in phase.
  // --------------------------------------------------------------------------
  logic [c_PRE_W-1:0] pre_q;
  logic [c_PRE_W-1:0] pre_d;
  logic               blink_tick;

  always_comb begin
    blink_tick = (pre_q == c_PRE_LAST);
    pre_d      = blink_tick ? '0 : pre_q + c_PRE_W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // --------------------------------------------------------------------------
  // Heartbeat: toggles when the divider wraps, first toggle at edge HB_DIV.
  // --------------------------------------------------------------------------
  logic [c_HB_W-1:0] hb_q;
  logic [c_HB_W-1:0] hb_d;
  logic              hb_wrap;
  logic              synth_q;
  logic              synth_d;

  always_comb begin
    hb_wrap = (hb_q == c_HB_LAST);
    hb_d    = hb_wrap ? '0 : hb_q + c_HB_W'(1);
    synth_d = hb_wrap ? ~synth_q : synth_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hb_q    <= '0;
      synth_q <= 1'b0;
    end else begin
      hb_q    <= hb_d;
      synth_q <= synth_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel mode register and display state.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] led_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e              mode_q;
    mode_e              mode_d;
    logic               led_q;
    logic               led_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               active_q;
    logic               active_d;
    logic               wr;

    // Full 5-bit compare: an out-of-range index never aliases onto a
    // lower channel.
    assign wr = cfg_we_i && (cfg_ch_i == 5'(i));

    always_comb begin
      mode_d   = mode_q;
      led_d    = led_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (wr) begin
        // A mode write always restarts the channel from a blank state,
        // even when the mode value is unchanged.
        mode_d   = mode_e'(cfg_mode_i);
        led_d    = 1'b0;
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        case (mode_q)
          MODE_DIRECT: begin
            led_d = probe_i[i];
          end
          MODE_STICKY: begin
            // Probe wins over clear when both are high.
            led_d = probe_i[i] | (led_q & ~clear_i[i]);
          end
          MODE_STRETCH: begin
            if (probe_i[i]) begin
              cnt_d = c_STRETCH_LOAD;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - c_CNT_W'(1);
            end
            // LED follows the next counter value so a single pulse gives
            // exactly STRETCH_CYCLES lit cycles.
            led_d = (cnt_d != '0);
          end
          MODE_BLINK: begin
            if (!probe_i[i]) begin
              led_d    = 1'b0;
              active_d = 1'b0;
            end else if (!active_q) begin
              led_d    = 1'b1;
              active_d = 1'b1;
            end else if (blink_tick) begin
              led_d = ~led_q;
            end
          end
          default: begin
            led_d = led_q;
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        mode_q   <= MODE_DIRECT;
        led_q    <= 1'b0;
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        led_q    <= led_d;
        cnt_q    <= cnt_d;
        active_q <= active_d;
      end
    end

    assign led_w[i] = led_q;
  end

  // --------------------------------------------------------------------------
  // Summary LED, one cycle behind the channel LEDs.
  // --------------------------------------------------------------------------
  logic any_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |led_w;
    end
  end

  assign led_prob_o  = led_w;
  assign led_any_o   = any_q;
  assign led_synth_o = synth_q;

endmodule
`default_nettype wire

// File: tb/tb_probe_led_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_probe_led_monitor
// Purpose  : Directed self-checking bench for probe_led_monitor with
//            NUM_CH=4, STRETCH_CYCLES=16, BLINK_DIV=8, HB_DIV=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_probe_led_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] probe;
  logic [3:0] clear;
  logic       cfg_we;
  logic [4:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] led_prob;
  logic       led_any;
  logic       led_synth;

  int checks = 0;
  int errors = 0;
  int edge_cnt;

  probe_led_monitor #(
    .NUM_CH        (4),
    .STRETCH_CYCLES(16),
    .BLINK_DIV     (8),
    .HB_DIV        (4)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .probe_i    (probe),
    .clear_i    (clear),
    .cfg_we_i   (cfg_we),
    .cfg_ch_i   (cfg_ch),
    .cfg_mode_i (cfg_mode),
    .led_prob_o (led_prob),
    .led_any_o  (led_any),
    .led_synth_o(led_synth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; used to predict blink ticks.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_mode(input logic [4:0] ch, input logic [1:0] m);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = m;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    probe = '0; clear = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    step(); step();
    checks++;
    if ({led_prob, led_any, led_synth} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000000", {led_prob, led_any, led_synth});
    end
    reset = 1'b0;
  endtask

  task automatic test_direct();
    logic [3:0] exp_led [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
    logic       exp_any [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      probe = (k < 3) ? 4'b1010 : 4'b0000;
      step();
      checks++;
      if (led_prob !== exp_led[k] || led_any !== exp_any[k]) begin
        errors++;
        $display("FAIL direct[%0d]: got led=%b any=%b, expected led=%b any=%b",
                 k, led_prob, led_any, exp_led[k], exp_any[k]);
      end
    end
  endtask

  task automatic test_sticky();
    logic held;
    set_mode(5'd0, 2'd1);
    probe = 4'b0001; step(); probe = 4'b0000;
    held = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (led_prob[0] !== 1'b1) held = 1'b0;
      step();
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold: led0 dropped within 100 cycles, expected held 1");
    end
    clear = 4'b0001; step(); clear = 4'b0000;
    checks++;
    if (led_prob[0] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b, expected 0", led_prob[0]);
    end
    // clear and probe together: probe wins. clear on a DIRECT channel is ignored.
    clear = 4'b0011; probe = 4'b0011; step(); clear = 4'b0000; probe = 4'b0000;
    checks++;
    if (led_prob[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL sticky_clear_probe: got %b, expected 11", led_prob[1:0]);
    end
    step();
    checks++;
    if (led_prob !== 4'b0001) begin
      errors++;
      $display("FAIL sticky_after: got %b, expected 0001", led_prob);
    end
  endtask

  task automatic stretch_run(input bit retrig, input int exp_hi);
    int hi;
    probe[1] = 1'b1; step(); probe[1] = 1'b0;
    hi = 0;
    for (int k = 0; k < 60; k++) begin
      if (led_prob[1] !== 1'b1) break;
      hi++;
      probe[1] = retrig && (hi == 10);
      step();
    end
    probe[1] = 1'b0;
    checks++;
    if (hi != exp_hi) begin
      errors++;
      $display("FAIL stretch_len(retrig=%0d): got %0d high cycles, expected %0d", retrig, hi, exp_hi);
    end
  endtask

  task automatic test_stretch();
    set_mode(5'd1, 2'd2);
    checks++;
    if (led_prob[1] !== 1'b0) begin
      errors++;
      $display("FAIL stretch_idle: got %b, expected 0", led_prob[1]);
    end
    stretch_run(1'b0, 16);
    step();
    stretch_run(1'b1, 26);
  endtask

  task automatic test_blink();
    logic exp_led;
    logic act;
    int   bad;
    int   e;
    set_mode(5'd2, 2'd3);
    exp_led = 1'b0; act = 1'b0; bad = 0;
    for (int k = 0; k < 64; k++) begin
      e = edge_cnt + 1;
      probe[2] = 1'b1;
      if (!act) begin
        exp_led = 1'b1; act = 1'b1;
      end else if (e % 8 == 0) begin
        exp_led = ~exp_led;
      end
      step();
      checks++;
      if (led_prob[2] !== exp_led) begin
        errors++;
        if (bad < 5) $display("FAIL blink[%0d]: got %b, expected %b", k, led_prob[2], exp_led);
        bad++;
      end
    end
    probe[2] = 1'b0;
    step();
    checks++;
    if (led_prob[2] !== 1'b0) begin
      errors++;
      $display("FAIL blink_drop: got %b, expected 0", led_prob[2]);
    end
  endtask

  task automatic test_cfg();
    set_mode(5'd7, 2'd1);
    checks++;
    if (led_prob !== 4'b0001) begin
      errors++;
      $display("FAIL cfg_oob_leds: got %b, expected 0001", led_prob);
    end
    // ch3 must still be DIRECT, not aliased to STICKY.
    probe = 4'b1000; step(); probe = 4'b0000; step();
    checks++;
    if (led_prob[3] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_oob_mode: ch3 got %b, expected 0 (DIRECT)", led_prob[3]);
    end
    set_mode(5'd0, 2'd1);
    checks++;
    if (led_prob[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_rewrite_clear: got %b, expected 0", led_prob[0]);
    end
    probe = 4'b0001; step(); probe = 4'b0000; step();
    checks++;
    if (led_prob[0] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_still_sticky: got %b, expected 1", led_prob[0]);
    end
  endtask

  task automatic test_reset_heartbeat();
    logic exp_hb;
    set_mode(5'd1, 2'd2);
    probe = 4'b0010; step(); probe = 4'b0000; step(); step();
    checks++;
    if (led_prob !== 4'b0011) begin
      errors++;
      $display("FAIL pre_reset: got %b, expected 0011", led_prob);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({led_prob, led_any, led_synth} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b, expected 000000", {led_prob, led_any, led_synth});
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      exp_hb = ((k / 4) % 2) == 1;
      checks++;
      if (led_synth !== exp_hb) begin
        errors++;
        $display("FAIL heartbeat[%0d]: got %b, expected %b", k, led_synth, exp_hb);
      end
    end
    probe = 4'b1111; step(); probe = 4'b0000;
    checks++;
    if (led_prob !== 4'b1111) begin
      errors++;
      $display("FAIL post_reset_on: got %b, expected 1111", led_prob);
    end
    step();
    checks++;
    if (led_prob !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_direct: got %b, expected 0000", led_prob);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_sticky();
    test_stretch();
    test_blink();
    test_cfg();
    test_reset_heartbeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
